bit_kosusu_kontrol: RTL and testbench
=====================================

Name: bit_kosusu_kontrol

Overview:
Sequencer for the bit_kosusu game engine. Replaces the divided slow clock with a single-cycle step enable in the `clk` domain, so there are no derived clocks. Captures ileri/don button presses and holds them as pending commands. Issues at most one command per step tick and tracks the game lifecycle: idle, running, finished. Sits between the board buttons and the engine, one instance per game.

Parameters:
- TICK_DIV, 100_000_000: `clk` cycles per step tick (1 Hz at 100 MHz); legal range is 2 or more.
- MOVE_W, 8: width of the move counter.
- MAX_MOVES, 200: move limit that forces a timeout finish; must be less than 2**MOVE_W.
- DEB_CYCLES, 1_000_000: required stable cycles per button; used only when debounce is compiled in.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- baslat, input, 1: start/restart button, asynchronous to `clk`.
- ileri, input, 1: forward button, asynchronous.
- don, input, 1: turn button, asynchronous.
- bitti_mi, input, 1: engine finished flag, synchronous to `clk`.
- step_en, output, 1: one-cycle engine step strobe.
- cmd_ileri, output, 1: forward command; valid only while step_en=1.
- cmd_don, output, 1: turn command; valid only while step_en=1.
- durum, output, 2: game state, encoded 00 IDLE, 01 RUN, 10 DONE.
- hamle_sayisi, output, MOVE_W: count of commands issued in the current game.
- zaman_asimi, output, 1: set when DONE was reached through MAX_MOVES rather than bitti_mi.

Behaviour:
- Reset is synchronous and active-low; it is sampled on the rising edge of clk. Reset values:
  - step_en, cmd_ileri, cmd_don = 0
  - durum = IDLE
  - hamle_sayisi = 0
  - zaman_asimi = 0
  - pending bits, tick counter and synchroniser flops = 0
- Reset mid-game aborts immediately. No step_en is emitted in the cycle after reset release.
- Input capture:
  - baslat, ileri and don each pass through a 2-flop synchroniser, followed by a rising-edge detector.
  - Edge latency is 3 clk from the pin to the internal one-cycle edge pulse.
- Pending commands:
  - The next value of each pending bit is (pend & ~consumed) | edge.
  - An edge in the same cycle as consumption re-arms the bit.
  - Multiple presses between ticks collapse to one pending command.
  - Pending bits are cleared on every entry to IDLE or DONE.
  - Edges are ignored outside RUN.
- Tick counter:
  - Runs only in RUN and is held at 0 otherwise.
  - Counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and raises an internal tick for one cycle.
  - The first tick after entering RUN arrives exactly TICK_DIV cycles after the RUN entry edge.
- On tick in RUN, all outputs are registered and change one cycle after the tick:
  - step_en = 1 for exactly one cycle.
  - If pend_don is set: cmd_don = 1 and pend_don is consumed. Turn has priority; pend_ileri stays pending for the next tick.
  - Else if pend_ileri is set: cmd_ileri = 1 and pend_ileri is consumed.
  - Else both commands are 0. The engine idles and the move is not counted.
  - cmd_ileri and cmd_don are never both 1.
  - hamle_sayisi increments on each tick that issues a command. It saturates at 2**MOVE_W-1.
- State machine:
  - IDLE -> RUN on a baslat edge. hamle_sayisi and zaman_asimi clear on the same edge.
  - RUN -> DONE when bitti_mi=1 is sampled in any cycle. step_en is suppressed from that cycle on, even if a tick coincides.
  - RUN -> DONE with zaman_asimi=1 on the cycle after hamle_sayisi reaches MAX_MOVES. The MAX_MOVES-th command is still issued.
  - If bitti_mi and the MAX_MOVES condition occur together, bitti_mi wins and zaman_asimi=0.
  - DONE -> IDLE on a baslat edge. hamle_sayisi and zaman_asimi hold their values in DONE and IDLE until the next start.
  - A baslat edge in RUN is ignored.
  - durum is the registered state.

Optional Feature:
- Macro: BIT_KOSUSU_KONTROL_DEBOUNCE_EN.
- Defined: each synchronised button must hold the same level for DEB_CYCLES consecutive clk cycles before its debounced level changes. Edge detection operates on the debounced level, so edge latency is 3+DEB_CYCLES clk.
- Undefined: no debounce logic; DEB_CYCLES is unused.

Decomposition:
- Package bit_kosusu_pkg holds:
  - the durum encodings IDLE, RUN, DONE, each 2 bits;
  - the command enum NONE, ILERI, DON.
- One sub-module, buton_yakala: 2-flop synchroniser, optional debounce under the macro, and rising-edge pulse. It is instantiated three times.

Test Plan (TICK_DIV=4, MAX_MOVES=3, debounce off):
1. Reset, then pulse baslat -> durum=RUN 4 clk later (3 sync + 1 FSM). The first step_en follows 4 clk after RUN entry with cmd_ileri=cmd_don=0, and hamle_sayisi stays 0.
2. In RUN, pulse ileri and don in the same cycle -> first tick gives cmd_don=1; next tick gives cmd_ileri=1; hamle_sayisi=2.
3. Press ileri three times within one tick period -> exactly one cmd_ileri; the following tick has no command.
4. Issue 3 commands with bitti_mi=0 -> after the third step, durum=DONE, zaman_asimi=1, no further step_en; a baslat edge then gives IDLE with hamle_sayisi still 3.
5. Assert bitti_mi in the same cycle a tick occurs -> no step_en is emitted, durum=DONE, zaman_asimi=0.
6. Pull rst_n low mid-RUN with commands pending -> the next cycle shows all outputs at reset values; after release, no step_en appears until a new baslat.

Source files
------------

// File: rtl/bit_kosusu_pkg.sv
// Shared encodings for the bit_kosusu sequencer: game state and issued command.
package bit_kosusu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } durum_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    ILERI = 2'b01,
    DON   = 2'b10
  } cmd_e;

endpackage

// File: rtl/bit_kosusu_kontrol_if.sv
// Engine-side bus of the sequencer: step strobe, command, status; the sequencer is master.
interface bit_kosusu_kontrol_if #(
  parameter int MOVE_W = 8
);
  logic              bitti_mi;
  logic              step_en;
  logic              cmd_ileri;
  logic              cmd_don;
  logic [1:0]        durum;
  logic [MOVE_W-1:0] hamle_sayisi;
  logic              zaman_asimi;

  modport master (
    input  bitti_mi,
    output step_en, cmd_ileri, cmd_don, durum, hamle_sayisi, zaman_asimi
  );

  modport slave (
    output bitti_mi,
    input  step_en, cmd_ileri, cmd_don, durum, hamle_sayisi, zaman_asimi
  );
endinterface

// File: rtl/buton_yakala.sv
// Button capture: 2-flop synchroniser, optional debounce, registered rising-edge pulse.
// Debounce is compiled in with BIT_KOSUSU_KONTROL_DEBOUNCE_EN.
module buton_yakala #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pulse
);

  logic s1, s2, lvl, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      prev  <= lvl;
      pulse <= lvl & ~prev;
    end
  end

`ifdef BIT_KOSUSU_KONTROL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt;
  logic          deb;

  // Level only follows s2 after it has disagreed for DEB_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      deb     <= 1'b0;
    end else if (s2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      deb     <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign lvl = deb;
`else
  assign lvl = s2;
`endif

endmodule

// File: rtl/bit_kosusu_kontrol.sv
// Game sequencer: step-enable generator, pending button commands and IDLE/RUN/DONE lifecycle.
// Optional button debounce under BIT_KOSUSU_KONTROL_DEBOUNCE_EN.
module bit_kosusu_kontrol
  import bit_kosusu_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MOVE_W     = 8,
  parameter int MAX_MOVES  = 200,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baslat,
  input  logic ileri,
  input  logic don,
  bit_kosusu_kontrol_if.master eng
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic bas_e, ile_e, don_e;

  buton_yakala #(.DEB_CYCLES(DEB_CYCLES)) u_bas (.clk(clk), .rst_n(rst_n), .pin(baslat), .pulse(bas_e));
  buton_yakala #(.DEB_CYCLES(DEB_CYCLES)) u_ile (.clk(clk), .rst_n(rst_n), .pin(ileri),  .pulse(ile_e));
  buton_yakala #(.DEB_CYCLES(DEB_CYCLES)) u_don (.clk(clk), .rst_n(rst_n), .pin(don),    .pulse(don_e));

  durum_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_ileri, pend_don;
  logic              step_q, cmd_ileri_q, cmd_don_q, zaman_q;
  logic [MOVE_W-1:0] hamle_q;

  logic tick, fire, hit_max, start, set_zaman;
  cmd_e cmd_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    set_zaman = 1'b0;
    tick      = (state_q == RUN) && (cnt_q == CNT_W'(TICK_DIV - 1));
    hit_max   = hamle_q >= MOVE_W'(MAX_MOVES);
    case (state_q)
      IDLE: if (bas_e) begin
        state_d = RUN;
        start   = 1'b1;
      end
      // bitti_mi outranks the move limit, so a tie finishes without timeout.
      RUN: if (eng.bitti_mi) begin
        state_d = DONE;
      end else if (hit_max) begin
        state_d   = DONE;
        set_zaman = 1'b1;
      end
      DONE: if (bas_e) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A tick in the cycle that leaves RUN never reaches the engine.
    fire    = tick && (state_d == RUN);
    cmd_sel = NONE;
    if (fire) begin
      if (pend_don)        cmd_sel = DON;
      else if (pend_ileri) cmd_sel = ILERI;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_ileri  <= 1'b0;
      pend_don    <= 1'b0;
      step_q      <= 1'b0;
      cmd_ileri_q <= 1'b0;
      cmd_don_q   <= 1'b0;
      zaman_q     <= 1'b0;
      hamle_q     <= '0;
    end else begin
      step_q      <= fire;
      cmd_ileri_q <= (cmd_sel == ILERI);
      cmd_don_q   <= (cmd_sel == DON);

      if (state_q == RUN && state_d == RUN) cnt_q <= tick ? '0 : cnt_q + 1'b1;
      else                                  cnt_q <= '0;

      // Edge arriving with a consumption re-arms; anything but staying in RUN clears.
      if (state_d != RUN) begin
        pend_ileri <= 1'b0;
        pend_don   <= 1'b0;
      end else begin
        pend_ileri <= (pend_ileri & ~(cmd_sel == ILERI)) | ((state_q == RUN) & ile_e);
        pend_don   <= (pend_don   & ~(cmd_sel == DON))   | ((state_q == RUN) & don_e);
      end

      if (start)                                 hamle_q <= '0;
      else if (cmd_sel != NONE && hamle_q != '1) hamle_q <= hamle_q + 1'b1;

      if (start)          zaman_q <= 1'b0;
      else if (set_zaman) zaman_q <= 1'b1;
    end
  end

  assign eng.step_en      = step_q;
  assign eng.cmd_ileri    = cmd_ileri_q;
  assign eng.cmd_don      = cmd_don_q;
  assign eng.durum        = state_q;
  assign eng.hamle_sayisi = hamle_q;
  assign eng.zaman_asimi  = zaman_q;

endmodule

// File: tb/tb_bit_kosusu_kontrol.sv
// Scenario bench for bit_kosusu_kontrol with TICK_DIV=4, MAX_MOVES=3; expected commands queued per step.
module tb_bit_kosusu_kontrol;
  localparam int TICK_DIV  = 4;
  localparam int MOVE_W    = 8;
  localparam int MAX_MOVES = 3;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ILERI = 2'b10;
  localparam logic [1:0] E_DON   = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baslat = 1'b0;
  logic ileri = 1'b0;
  logic don = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  bit_kosusu_kontrol_if #(.MOVE_W(MOVE_W)) bus ();

  bit_kosusu_kontrol #(
    .TICK_DIV(TICK_DIV), .MOVE_W(MOVE_W), .MAX_MOVES(MAX_MOVES), .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baslat(baslat), .ileri(ileri), .don(don), .eng(bus)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Buttons high for exactly one sampled edge.
  task automatic pulse(input logic b, input logic i, input logic d);
    baslat = b; ileri = i; don = d;
    step_clk();
    baslat = 1'b0; ileri = 1'b0; don = 1'b0;
  endtask

  // Scoreboard pop: the next step strobe must carry the oldest queued command.
  task automatic wait_step(input string name, input int budget);
    logic [1:0] e;
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step_clk();
      if (bus.step_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no step_en within %0d cycles", name, budget);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: step_en with empty scoreboard, cmd=%b", name, {bus.cmd_ileri, bus.cmd_don});
    end else begin
      e = exp_q.pop_front();
      if ({bus.cmd_ileri, bus.cmd_don} !== e) begin
        errors++;
        $display("FAIL %s: cmd {ileri,don} got %b want %b", name, {bus.cmd_ileri, bus.cmd_don}, e);
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      step_clk();
      checks++;
      if (bus.step_en !== 1'b0) begin
        errors++;
        $display("FAIL %s: step_en got %b want 0 at cycle %0d", name, bus.step_en, k);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bitti_mi = 1'b0;
    repeat (3) step_clk();
    checks++;
    if ({bus.step_en, bus.cmd_ileri, bus.cmd_don, bus.zaman_asimi} !== 4'b0 ||
        bus.durum !== 2'b00 || bus.hamle_sayisi !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: step/ileri/don/zaman=%b durum=%b hamle=%0d want 0000 00 0",
               {bus.step_en, bus.cmd_ileri, bus.cmd_don, bus.zaman_asimi}, bus.durum, bus.hamle_sayisi);
    end
    rst_n = 1'b1;
    idle_cycles("idle_after_reset", 6);
  endtask

  task automatic test_start();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) step_clk();
    checks++;
    if (bus.durum !== 2'b00) begin
      errors++;
      $display("FAIL start_early: durum got %b want 00", bus.durum);
    end
    step_clk();
    checks++;
    if (bus.durum !== 2'b01 || bus.hamle_sayisi !== 8'd0 || bus.zaman_asimi !== 1'b0) begin
      errors++;
      $display("FAIL start_run: durum=%b hamle=%0d zaman=%b want 01 0 0",
               bus.durum, bus.hamle_sayisi, bus.zaman_asimi);
    end
    exp_q.push_back(E_NONE);
    repeat (3) step_clk();
    checks++;
    if (bus.step_en !== 1'b0) begin
      errors++;
      $display("FAIL first_tick_early: step_en got %b want 0", bus.step_en);
    end
    wait_step("first_tick", 1);
    checks++;
    if (bus.hamle_sayisi !== 8'd0) begin
      errors++;
      $display("FAIL first_tick_count: hamle got %0d want 0", bus.hamle_sayisi);
    end
  endtask

  task automatic test_both_pressed();
    exp_q.push_back(E_NONE);
    exp_q.push_back(E_DON);
    exp_q.push_back(E_ILERI);
    exp_q.push_back(E_NONE);
    pulse(1'b0, 1'b1, 1'b1);
    wait_step("both_arrive", 6);
    wait_step("both_don_first", 6);
    wait_step("both_ileri_next", 6);
    checks++;
    if (bus.hamle_sayisi !== 8'd2) begin
      errors++;
      $display("FAIL both_count: hamle got %0d want 2", bus.hamle_sayisi);
    end
    wait_step("both_drained", 6);
  endtask

  task automatic test_bitti_on_tick();
    repeat (3) step_clk();
    bus.bitti_mi = 1'b1;
    step_clk();
    checks++;
    if (bus.step_en !== 1'b0 || bus.durum !== 2'b10 || bus.zaman_asimi !== 1'b0 || bus.hamle_sayisi !== 8'd2) begin
      errors++;
      $display("FAIL bitti_tick: step=%b durum=%b zaman=%b hamle=%0d want 0 10 0 2",
               bus.step_en, bus.durum, bus.zaman_asimi, bus.hamle_sayisi);
    end
    bus.bitti_mi = 1'b0;
    idle_cycles("no_step_in_done", 8);
  endtask

  task automatic test_restart();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) step_clk();
    checks++;
    if (bus.durum !== 2'b00 || bus.hamle_sayisi !== 8'd2 || bus.zaman_asimi !== 1'b0) begin
      errors++;
      $display("FAIL done_to_idle: durum=%b hamle=%0d zaman=%b want 00 2 0",
               bus.durum, bus.hamle_sayisi, bus.zaman_asimi);
    end
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) step_clk();
    checks++;
    if (bus.durum !== 2'b01 || bus.hamle_sayisi !== 8'd0) begin
      errors++;
      $display("FAIL idle_to_run: durum=%b hamle=%0d want 01 0", bus.durum, bus.hamle_sayisi);
    end
  endtask

  // Pending turn holds ileri across a tick while three ileri presses land.
  task automatic test_collapse();
    pulse(1'b0, 1'b1, 1'b1);
    step_clk();
    pulse(1'b0, 1'b1, 1'b0);
    step_clk();
    checks++;
    if (bus.step_en !== 1'b1 || {bus.cmd_ileri, bus.cmd_don} !== E_NONE) begin
      errors++;
      $display("FAIL collapse_tick0: step=%b cmd=%b want 1 00", bus.step_en, {bus.cmd_ileri, bus.cmd_don});
    end
    exp_q.push_back(E_DON);
    exp_q.push_back(E_ILERI);
    exp_q.push_back(E_NONE);
    pulse(1'b0, 1'b1, 1'b0);
    wait_step("collapse_don", 6);
    wait_step("collapse_one_ileri", 6);
    wait_step("collapse_no_repeat", 6);
    checks++;
    if (bus.hamle_sayisi !== 8'd2) begin
      errors++;
      $display("FAIL collapse_count: hamle got %0d want 2", bus.hamle_sayisi);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back(E_NONE);
    exp_q.push_back(E_ILERI);
    pulse(1'b1, 1'b1, 1'b0);
    wait_step("timeout_gap", 6);
    wait_step("timeout_last_cmd", 6);
    checks++;
    if (bus.hamle_sayisi !== 8'd3 || bus.durum !== 2'b01) begin
      errors++;
      $display("FAIL timeout_third: hamle=%0d durum=%b want 3 01", bus.hamle_sayisi, bus.durum);
    end
    step_clk();
    checks++;
    if (bus.durum !== 2'b10 || bus.zaman_asimi !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: durum=%b zaman=%b want 10 1", bus.durum, bus.zaman_asimi);
    end
    idle_cycles("timeout_quiet", 10);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) step_clk();
    checks++;
    if (bus.durum !== 2'b00 || bus.hamle_sayisi !== 8'd3 || bus.zaman_asimi !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle_hold: durum=%b hamle=%0d zaman=%b want 00 3 1",
               bus.durum, bus.hamle_sayisi, bus.zaman_asimi);
    end
  endtask

  task automatic test_mid_reset();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) step_clk();
    checks++;
    if (bus.durum !== 2'b01 || bus.hamle_sayisi !== 8'd0 || bus.zaman_asimi !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears: durum=%b hamle=%0d zaman=%b want 01 0 0",
               bus.durum, bus.hamle_sayisi, bus.zaman_asimi);
    end
    exp_q.push_back(E_NONE);
    pulse(1'b0, 1'b0, 1'b1);
    wait_step("midreset_tick", 6);
    repeat (2) step_clk();
    rst_n = 1'b0;
    step_clk();
    checks++;
    if ({bus.step_en, bus.cmd_ileri, bus.cmd_don, bus.zaman_asimi} !== 4'b0 ||
        bus.durum !== 2'b00 || bus.hamle_sayisi !== 8'd0) begin
      errors++;
      $display("FAIL midreset_values: step/ileri/don/zaman=%b durum=%b hamle=%0d want 0000 00 0",
               {bus.step_en, bus.cmd_ileri, bus.cmd_don, bus.zaman_asimi}, bus.durum, bus.hamle_sayisi);
    end
    step_clk();
    rst_n = 1'b1;
    idle_cycles("after_midreset", 12);
    checks++;
    if (bus.durum !== 2'b00) begin
      errors++;
      $display("FAIL after_midreset_state: durum got %b want 00", bus.durum);
    end
  endtask

  initial begin
    bus.bitti_mi = 1'b0;
    test_reset();
    test_start();
    test_both_pressed();
    test_bitti_on_tick();
    test_restart();
    test_collapse();
    test_timeout();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected steps never seen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
